// File: rtl/combo_lock_ctrl_if.sv
// Digit-entry strobes from the key logic and status outputs toward the HEX decoder.
interface combo_lock_ctrl_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       prog_req;
    logic       open;
    logic       closed;
    logic       error;
    logic       locked;
    logic       prog_mode;
    logic [2:0] idx;
    logic [1:0] fail_cnt;

    modport master (
        output digit_valid, digit, clear, prog_req,
        input  open, closed, error, locked, prog_mode, idx, fail_cnt
    );

    modport slave (
        input  digit_valid, digit, clear, prog_req,
        output open, closed, error, locked, prog_mode, idx, fail_cnt
    );
endinterface

// File: rtl/combo_lock_ctrl.sv
// Six-digit combination lock sequencer: attempt checking, fail counting,
// timed lockout and re-programming of the code while open.
module combo_lock_ctrl #(
    parameter int                  NDIG           = 6,
    parameter logic [4*NDIG-1:0]   DEFAULT_CODE   = 24'h344189,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              reset,
    combo_lock_ctrl_if.slave lockIf
);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_OPEN,
        S_CLOSED,
        S_ERROR,
        S_LOCKOUT,
        S_PROG,
        S_ABORT
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NDIG - 1);
    localparam logic [1:0] FAIL_LIM  = 2'(MAX_FAIL);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

    state_t             state_q, state_d;
    logic [4*NDIG-1:0]  code_q, code_d;
    logic [4*NDIG-1:0]  shadow_q, shadow_d;
    logic [4*NDIG-1:0]  shadowNext;
    logic [2:0]         idx_q, idx_d;
    logic               mismatch_q, mismatch_d;
    logic               mismatchNew;
    logic [1:0]         failCnt_q, failCnt_d;
    logic [1:0]         failInc;
    logic [7:0]         lockCnt_q, lockCnt_d;
    logic [3:0]         expDigit;
    logic               digitBad;
    logic               open_q, closed_q, error_q, locked_q, progMode_q;

    // Nibble of the stored code at the current position, and the shadow
    // register with the incoming digit written at that position.
    always_comb begin
        expDigit   = '0;
        shadowNext = shadow_q;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == 3'(i)) begin
                expDigit = code_q[4*(NDIG-1-i) +: 4];
                shadowNext[4*(NDIG-1-i) +: 4] = lockIf.digit;
            end
        end
    end

    assign digitBad    = (lockIf.digit > 4'd9);
    assign mismatchNew = mismatch_q | (lockIf.digit != expDigit);
    assign failInc     = failCnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        failCnt_d  = failCnt_q;
        lockCnt_d  = lockCnt_q;

        unique case (state_q)
            S_ENTRY: begin
                if (lockIf.clear) begin
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end else if (lockIf.digit_valid) begin
                    // The lockout counter is preloaded on any failure; it only
                    // matters if the failure pushes the count to the limit.
                    if (digitBad) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        failCnt_d  = failInc;
                        lockCnt_d  = LOCK_LOAD;
                        state_d    = (failInc == FAIL_LIM) ? S_LOCKOUT : S_ERROR;
                    end else if (idx_q >= LAST_IDX) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!mismatchNew) begin
                            failCnt_d = '0;
                            state_d   = S_OPEN;
                        end else begin
                            failCnt_d = failInc;
                            lockCnt_d = LOCK_LOAD;
                            state_d   = (failInc == FAIL_LIM) ? S_LOCKOUT : S_CLOSED;
                        end
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        mismatch_d = mismatchNew;
                    end
                end
            end

            S_OPEN: begin
                if (lockIf.clear) begin
                    state_d    = S_ENTRY;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end else if (lockIf.prog_req) begin
                    state_d = S_PROG;
                    idx_d   = '0;
                end
            end

            S_CLOSED, S_ERROR: begin
                if (lockIf.clear) begin
                    state_d    = S_ENTRY;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end
            end

            S_LOCKOUT: begin
                lockCnt_d = lockCnt_q - 8'd1;
                if (lockCnt_q <= 8'd1) begin
                    state_d   = S_ENTRY;
                    failCnt_d = '0;
                end
            end

            S_PROG: begin
                if (lockIf.clear) begin
                    state_d    = S_ENTRY;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end else if (lockIf.digit_valid) begin
                    if (digitBad) begin
                        state_d = S_ABORT;
                        idx_d   = '0;
                    end else if (idx_q >= LAST_IDX) begin
                        code_d  = shadowNext;
                        state_d = S_OPEN;
                        idx_d   = '0;
                    end else begin
                        shadow_d = shadowNext;
                        idx_d    = idx_q + 3'd1;
                    end
                end
            end

            // One-cycle error pulse after an aborted programming pass.
            S_ABORT: begin
                state_d = S_OPEN;
                idx_d   = '0;
            end

            default: begin
                state_d = S_ENTRY;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_ENTRY;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            failCnt_q  <= '0;
            lockCnt_q  <= '0;
            open_q     <= 1'b0;
            closed_q   <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
            progMode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            failCnt_q  <= failCnt_d;
            lockCnt_q  <= lockCnt_d;
            open_q     <= (state_d == S_OPEN);
            closed_q   <= (state_d == S_CLOSED);
            error_q    <= (state_d == S_ERROR) || (state_d == S_ABORT);
            locked_q   <= (state_d == S_LOCKOUT);
            progMode_q <= (state_d == S_PROG);
        end
    end

    assign lockIf.open      = open_q;
    assign lockIf.closed    = closed_q;
    assign lockIf.error     = error_q;
    assign lockIf.locked    = locked_q;
    assign lockIf.prog_mode = progMode_q;
    assign lockIf.idx       = idx_q;
    assign lockIf.fail_cnt  = failCnt_q;

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Sequencing controller for the lab's six-digit combination lock. It accepts one decimal digit per strobe and compares it against a programmable code register. It reports OPEN, CLOSED or ERROR, counts failed attempts and enforces a timed lockout. While OPEN, the user can re-program the combination. It sits between the debounced switch/key logic and the HEX display decoder in the lock top level.

## Interface

- NDIG, 6: digits per combination
- DEFAULT_CODE, 24'h344189: combination loaded at reset; the first digit is in the most-significant nibble
- MAX_FAIL, 3: failed attempts that trigger lockout (valid range 1..3)
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles (valid range 1..255)

- clk  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- digit_valid  input  1  one-cycle strobe, digit is sampled when high
- digit  input  4  entered value; 0..9 is valid, 10..15 is invalid
- clear  input  1  one-cycle strobe that restarts entry or relocks
- prog_req  input  1  one-cycle strobe that enters programming mode (honoured only in OPEN)
- open  output  1  lock open
- closed  output  1  wrong combination entered
- error  output  1  invalid digit entered during an attempt
- locked  output  1  lockout active
- prog_mode  output  1  programming in progress
- idx  output  3  digits accepted in the current attempt or programming pass (0..NDIG)
- fail_cnt  output  2  failed attempts since the last success, lockout expiry or reset

## Operation

- States:
  - ENTRY: collecting an attempt.
  - OPEN: combination accepted.
  - CLOSED: wrong combination.
  - ERROR: invalid digit during an attempt.
  - LOCKOUT: timed lockout.
  - PROG: collecting a new combination.
- Reset sets state to ENTRY and code to DEFAULT_CODE. It also clears idx, the mismatch flag, fail_cnt and the lockout counter. All outputs are 0 after reset.
- ENTRY, digit_valid with digit ≤ 9:
  - mismatch |= (digit != code nibble[idx]); idx increments.
  - On the NDIG-th digit, if no mismatch including this digit: go to OPEN and set fail_cnt = 0.
  - On the NDIG-th digit with a mismatch: fail_cnt increments, then go to CLOSED, or to LOCKOUT if the new fail_cnt equals MAX_FAIL.
- ENTRY, digit_valid with digit > 9:
  - fail_cnt increments; go to ERROR, or to LOCKOUT if the new fail_cnt equals MAX_FAIL.
  - A digit > 9 fails immediately, without waiting for NDIG digits.
- CLOSED and ERROR hold their state and ignore digit_valid and prog_req. On clear, go to ENTRY with idx = 0 and mismatch = 0; fail_cnt is retained.
- LOCKOUT:
  - On entry, the counter loads LOCKOUT_CYCLES.
  - The counter decrements every cycle. When it reaches 0, go to ENTRY and set fail_cnt = 0.
  - All inputs except reset are ignored.
- OPEN:
  - On clear, go to ENTRY (relock).
  - On prog_req, go to PROG with idx = 0.
  - digit_valid is ignored.
- PROG:
  - A valid digit writes shadow nibble[idx] and idx increments.
  - After NDIG digits, the shadow register is copied to code in one cycle, then go to OPEN with idx = 0.
  - A digit > 9 aborts: code is unchanged, go to OPEN, and error pulses high for exactly one cycle.
  - clear aborts: code is unchanged, go to ENTRY.
- Priority within a cycle: reset > clear > prog_req > digit_valid. In ENTRY, clear restarts the attempt and any simultaneous digit is dropped.
- Output decode:
  - open = OPEN; closed = CLOSED; locked = LOCKOUT; prog_mode = PROG.
  - error = ERROR, plus the one-cycle PROG-abort pulse.
  - Exactly one of open, closed, error, locked, prog_mode may be high in any cycle. In ENTRY all five are low.
- idx saturates at NDIG and is never observable above NDIG. It reads 0 in OPEN, CLOSED, ERROR and LOCKOUT.

## Timing

- All outputs are registered. A strobe sampled at edge N is reflected in the outputs after edge N (visible during cycle N+1).
- Latency from the final digit strobe to open or closed is 1 cycle. There is no additional compare latency.
- locked is high for exactly LOCKOUT_CYCLES consecutive cycles. ENTRY is reachable on the following cycle, and a digit strobed in that cycle is accepted.
- Back-to-back digit_valid strobes on consecutive cycles must all be accepted.
- Reset asserted mid-operation (PROG, LOCKOUT, partial ENTRY) takes effect on the next edge. A partially entered new code is discarded and code returns to DEFAULT_CODE.

## Test plan

- Reset, then strobe 3,4,4,1,8,9 → idx counts 1..5; open = 1 one cycle after the 6th strobe; fail_cnt = 0.
- Strobe 3,4,5,1,8,9 → closed = 1 only after the 6th strobe; fail_cnt = 1. A further digit 2 is ignored and closed stays 1. clear → ENTRY with fail_cnt = 1.
- Three wrong attempts separated by clear → after the 3rd, locked = 1 for exactly 16 cycles and digits during that window are ignored. Then ENTRY with fail_cnt = 0, and 3,4,4,1,8,9 opens.
- From reset, strobe digit 12 → error = 1 next cycle; fail_cnt = 1; idx = 0. clear → ENTRY.
- In OPEN: prog_req, then 1,2,3,4,5,6 → prog_mode for 6 strobes, then open. clear; 3,4,4,1,8,9 → closed. clear; 1,2,3,4,5,6 → open.
- In PROG after 1,2,3, assert reset → all outputs 0 and 3,4,4,1,8,9 opens. Separately, digit 11 in PROG → one-cycle error pulse, open, and the old code still valid.
